// File: rtl/inst_queue.sv
// Instruction queue between fetch (F2) and issue (I). Up to two pushes and two
// pops per cycle. Head entries are presented straight from storage.
module inst_queue #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_que,
  input  logic                     stallI,
  input  logic [1:0]               in_valid,
  input  logic [PC_W-1:0]          in_pc0,
  input  logic [INST_W-1:0]        in_inst0,
  input  logic [PC_W-1:0]          in_pc1,
  input  logic [INST_W-1:0]        in_inst1,
  input  logic [1:0]               pop_req,
  output logic [1:0]               out_valid,
  output logic [PC_W-1:0]          out_pc0,
  output logic [INST_W-1:0]        out_inst0,
  output logic [PC_W-1:0]          out_pc1,
  output logic [INST_W-1:0]        out_inst1,
  output logic                     overflowI,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: the producer's slots are taken only while overflowI is low,
  // otherwise it is stalled and re-presents the same data. The consumer's
  // pop_req is honoured up to the occupancy (clamped) unless stallI is high.

  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [1:0]        w_push_n;
  logic [1:0]        w_req_n;
  logic [1:0]        w_pop_n;
  logic [AW-1:0]     w_head1;
  logic [AW-1:0]     w_tail1;
  logic              w_overflow;
  logic              w_clear;

  assign w_head1    = r_head + AW'(1);
  assign w_tail1    = r_tail + AW'(1);
  assign w_clear    = reset | flush_que;
  // Fewer than two free slots means a 2-wide push might not fit.
  assign w_overflow = (r_count >= CW'(DEPTH - 1));

  always_comb begin
    w_push_n = 2'd0;
    w_req_n  = 2'd0;
    w_pop_n  = 2'd0;
    if (in_valid == 2'b11)      w_push_n = 2'd2;
    else if (in_valid == 2'b01) w_push_n = 2'd1;
    if (w_overflow)             w_push_n = 2'd0;
    if (pop_req == 2'b11)       w_req_n = 2'd2;
    else if (pop_req == 2'b01)  w_req_n = 2'd1;
    if (CW'(w_req_n) > r_count) w_pop_n = r_count[1:0];
    else                        w_pop_n = w_req_n;
    if (stallI)                 w_pop_n = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop_n);
      r_tail  <= r_tail + AW'(w_push_n);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

  // Storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (!w_clear && w_push_n != 2'd0) begin
      r_pc_mem[r_tail]   <= in_pc0;
      r_inst_mem[r_tail] <= in_inst0;
    end
    if (!w_clear && w_push_n == 2'd2) begin
      r_pc_mem[w_tail1]   <= in_pc1;
      r_inst_mem[w_tail1] <= in_inst1;
    end
  end

  assign out_pc0      = r_pc_mem[r_head];
  assign out_inst0    = r_inst_mem[r_head];
  assign out_pc1      = r_pc_mem[w_head1];
  assign out_inst1    = r_inst_mem[w_head1];
  assign out_valid[0] = (r_count != '0);
  assign out_valid[1] = (r_count >= CW'(2));
  assign overflowI    = w_overflow;
  assign count        = r_count;

endmodule
